// File: rtl/ddr3_arb_pkg.sv
// Shared types and constants for the DDR3 arbiter command generator.
// State encoding, burst size and MIG command codes.
package ddr3_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int BURST_WORDS = 16;
    localparam int CNT_W       = 9;
    localparam int HOLD_W      = 4;

    localparam logic [2:0] CMD_RD = 3'b001;
    localparam logic [2:0] CMD_WR = 3'b000;

endpackage

// File: rtl/ddr3_arb_cmd_gen.sv
// Turns one arbitration winner into a run of 16-word MIG commands,
// then masks the stale request with a short holdoff window.
module ddr3_arb_cmd_gen
    import ddr3_arb_pkg::*;
#(
    parameter int HOLDOFF = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_soft_rst,
    input  logic        i_ch_req,
    input  logic [4:0]  i_ch_num,
    input  logic        i_ch_rd_wrn,
    input  logic [26:0] i_ch_start_addr,
    input  logic [11:0] i_ch_length,
    output logic        o_grant,
    output logic [4:0]  o_grant_num,
    output logic        o_busy,
    output logic        o_app_en,
    output logic [2:0]  o_app_cmd,
    output logic [26:0] o_app_addr,
    input  logic        i_app_rdy,
    output logic        o_done,
    output logic [4:0]  o_done_num
);

    state_e              state_q, state_d;
    logic [4:0]          num_q;
    logic                rd_wrn_q;
    logic [26:0]         addr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [HOLD_W-1:0]   hold_q;
    logic                grant_q;
    logic                zl_done_q;

    logic                clr;
    logic                accept;
    logic                zero_len;
    logic                cmd_fire;
    logic                last_cmd;
    logic [12:0]         len_ceil;
    logic                unused_bits;

    assign clr      = !i_rst_n || i_soft_rst;
    assign accept   = (state_q == ST_IDLE) && i_ch_req && (hold_q == '0);
    assign zero_len = (i_ch_length == '0);
    assign cmd_fire = (state_q == ST_CMD) && i_app_rdy;
    assign last_cmd = (cnt_q == CNT_W'(1));
    assign len_ceil = {1'b0, i_ch_length} + 13'(BURST_WORDS - 1);

    assign unused_bits = ^{i_ch_start_addr[3:0], len_ceil[3:0]};

    always_ff @(posedge i_clk) begin
        if (clr) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept && !zero_len) state_d = ST_CMD;
            ST_CMD:  if (cmd_fire && last_cmd) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_busy      = (state_q != ST_IDLE);
        o_app_en    = (state_q == ST_CMD);
        o_app_cmd   = rd_wrn_q ? CMD_RD : CMD_WR;
        o_app_addr  = addr_q;
        o_grant     = grant_q;
        o_grant_num = num_q;
        o_done      = (state_q == ST_DONE) || zl_done_q;
        o_done_num  = num_q;
    end

    always_ff @(posedge i_clk) begin
        if (clr) begin
            num_q     <= '0;
            rd_wrn_q  <= 1'b0;
            addr_q    <= '0;
            cnt_q     <= '0;
            hold_q    <= '0;
            grant_q   <= 1'b0;
            zl_done_q <= 1'b0;
        end else begin
            grant_q   <= accept;
            zl_done_q <= accept && zero_len;
            if (hold_q != '0) hold_q <= hold_q - 1'b1;
            if (accept) begin
                num_q    <= i_ch_num;
                rd_wrn_q <= i_ch_rd_wrn;
                addr_q   <= {i_ch_start_addr[26:4], 4'b0000};
                cnt_q    <= len_ceil[12:4];
                // A zero-length grant completes at once, so it arms holdoff itself
                if (zero_len) hold_q <= HOLD_W'(HOLDOFF);
            end
            if (cmd_fire) begin
                addr_q <= addr_q + 27'(BURST_WORDS);
                cnt_q  <= cnt_q - 1'b1;
            end
            if (state_q == ST_DONE) hold_q <= HOLD_W'(HOLDOFF);
        end
    end

endmodule

// File: tb/tb_ddr3_arb_cmd_gen.sv
// Directed bench for the DDR3 arbiter command generator.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_ddr3_arb_cmd_gen;

    localparam int HOLD = 4;

    logic        clk = 1'b0;
    logic        rst_n, soft_rst;
    logic        ch_req, ch_rd_wrn, app_rdy;
    logic [4:0]  ch_num;
    logic [26:0] ch_addr;
    logic [11:0] ch_len;
    logic        grant, busy, app_en, done;
    logic [4:0]  grant_num, done_num;
    logic [2:0]  app_cmd;
    logic [26:0] app_addr;

    int tests = 0;
    int fails = 0;

    ddr3_arb_cmd_gen #(.HOLDOFF(HOLD)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_soft_rst(soft_rst),
        .i_ch_req(ch_req),
        .i_ch_num(ch_num),
        .i_ch_rd_wrn(ch_rd_wrn),
        .i_ch_start_addr(ch_addr),
        .i_ch_length(ch_len),
        .o_grant(grant),
        .o_grant_num(grant_num),
        .o_busy(busy),
        .o_app_en(app_en),
        .o_app_cmd(app_cmd),
        .o_app_addr(app_addr),
        .i_app_rdy(app_rdy),
        .o_done(done),
        .o_done_num(done_num)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [4:0] n, input logic rd,
                       input logic [26:0] a, input logic [11:0] l);
        ch_req    = 1'b1;
        ch_num    = n;
        ch_rd_wrn = rd;
        ch_addr   = a;
        ch_len    = l;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; soft_rst = 1'b0; app_rdy = 1'b1;
        ch_req = 1'b0; ch_num = '0; ch_rd_wrn = 1'b0;
        ch_addr = '0; ch_len = '0;
        tick(); tick();
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_app_en", 32'(app_en), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_addr", 32'(app_addr), 0);
        chk("rst_cmd", 32'(app_cmd), 0);
        rst_n = 1'b1;
        tick();

        // 32-word read
        req(5'd5, 1'b1, 27'h100, 12'd32);
        tick();
        ch_req = 1'b0;
        chk("rd_grant", 32'(grant), 1);
        chk("rd_grant_num", 32'(grant_num), 5);
        chk("rd_app_en0", 32'(app_en), 1);
        chk("rd_cmd", 32'(app_cmd), 1);
        chk("rd_addr0", 32'(app_addr), 32'h100);
        tick();
        chk("rd_grant_pulse", 32'(grant), 0);
        chk("rd_addr1", 32'(app_addr), 32'h110);
        chk("rd_done_early", 32'(done), 0);
        tick();
        chk("rd_done", 32'(done), 1);
        chk("rd_done_num", 32'(done_num), 5);
        chk("rd_app_en_off", 32'(app_en), 0);
        tick();
        chk("rd_done_pulse", 32'(done), 0);
        chk("rd_idle", 32'(busy), 0);
        repeat (6) tick();

        // unaligned write with backpressure
        app_rdy = 1'b0;
        req(5'd7, 1'b0, 27'h10F, 12'd17);
        tick();
        ch_req = 1'b0;
        chk("wr_grant", 32'(grant), 1);
        chk("wr_cmd", 32'(app_cmd), 0);
        chk("wr_addr0", 32'(app_addr), 32'h100);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wr_hold0_en", 32'(app_en), 1);
            chk("wr_hold0_addr", 32'(app_addr), 32'h100);
        end
        app_rdy = 1'b1;
        tick();
        app_rdy = 1'b0;
        chk("wr_addr1", 32'(app_addr), 32'h110);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wr_hold1_en", 32'(app_en), 1);
            chk("wr_hold1_addr", 32'(app_addr), 32'h110);
            chk("wr_hold1_cmd", 32'(app_cmd), 0);
        end
        app_rdy = 1'b1;
        tick();
        chk("wr_done", 32'(done), 1);
        chk("wr_done_num", 32'(done_num), 7);
        chk("wr_app_en_off", 32'(app_en), 0);
        repeat (6) tick();

        // zero length then held request through holdoff
        req(5'd3, 1'b1, 27'h0, 12'd0);
        tick();
        chk("zl_grant", 32'(grant), 1);
        chk("zl_done", 32'(done), 1);
        chk("zl_done_num", 32'(done_num), 3);
        chk("zl_app_en", 32'(app_en), 0);
        chk("zl_busy", 32'(busy), 0);
        req(5'd9, 1'b1, 27'h200, 12'd20);
        n = 0;
        do begin
            tick();
            n++;
            if (app_en && !grant) begin
                chk("zl_app_en_early", 32'(app_en), 0);
            end
        end while (!grant && n < 20);
        ch_req = 1'b0;
        chk("ho_spacing", 32'(n), 32'(HOLD + 1));
        chk("ho_grant_num", 32'(grant_num), 9);
        chk("ho_addr0", 32'(app_addr), 32'h200);
        tick();
        chk("ho_addr1", 32'(app_addr), 32'h210);
        tick();
        chk("ho_done", 32'(done), 1);
        chk("ho_done_num", 32'(done_num), 9);
        repeat (6) tick();

        // max length with address wrap
        req(5'd2, 1'b1, 27'h7FFFF80, 12'd4095);
        tick();
        ch_req = 1'b0;
        chk("mx_addr0", 32'(app_addr), 32'h7FFFF80);
        n = 0;
        for (int i = 1; i < 256; i++) begin
            tick();
            if (app_en) n++;
            if (i == 7) chk("mx_addr_top", 32'(app_addr), 32'h7FFFFF0);
            if (i == 8) chk("mx_addr_wrap", 32'(app_addr), 32'h0);
        end
        chk("mx_cmds", 32'(n + 1), 256);
        chk("mx_addr_last", 32'(app_addr), 32'hF70);
        chk("mx_not_done", 32'(done), 0);
        tick();
        chk("mx_done", 32'(done), 1);
        chk("mx_done_num", 32'(done_num), 2);
        chk("mx_app_en_off", 32'(app_en), 0);
        repeat (6) tick();

        // soft reset aborts a transfer
        req(5'd4, 1'b0, 27'h400, 12'd64);
        tick();
        ch_req = 1'b0;
        chk("sr_grant", 32'(grant), 1);
        tick();
        tick();
        chk("sr_addr2", 32'(app_addr), 32'h420);
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        chk("sr_app_en", 32'(app_en), 0);
        chk("sr_busy", 32'(busy), 0);
        chk("sr_done", 32'(done), 0);
        chk("sr_addr", 32'(app_addr), 0);
        chk("sr_grant_num", 32'(grant_num), 0);
        req(5'd6, 1'b1, 27'h500, 12'd16);
        tick();
        ch_req = 1'b0;
        chk("sr_regrant", 32'(grant), 1);
        chk("sr_regrant_num", 32'(grant_num), 6);
        chk("sr_readdr", 32'(app_addr), 32'h500);
        tick();
        chk("sr_redone", 32'(done), 1);
        chk("sr_redone_num", 32'(done_num), 6);
        repeat (6) tick();

        // hard reset during CMD
        app_rdy = 1'b0;
        req(5'd8, 1'b1, 27'h800, 12'd64);
        tick();
        ch_req = 1'b0;
        chk("hr_app_en_pre", 32'(app_en), 1);
        rst_n = 1'b0;
        app_rdy = 1'b1;
        tick();
        chk("hr_app_en", 32'(app_en), 0);
        chk("hr_busy", 32'(busy), 0);
        chk("hr_grant", 32'(grant), 0);
        chk("hr_done", 32'(done), 0);
        chk("hr_grant_num", 32'(grant_num), 0);
        chk("hr_done_num", 32'(done_num), 0);
        chk("hr_cmd", 32'(app_cmd), 0);
        chk("hr_addr", 32'(app_addr), 0);
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
